// File: rtl/strobe_capture.sv
// Input front end: synchronises an async data bus and strobes, filters each strobe,
// detects accepted edges and latches the synced data word per channel on the chosen edge.
`timescale 1ns/1ps
module strobe_capture #(
  parameter int DATA_W       = 4,
  parameter int STROBE_W     = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_LEN   = 3,
  parameter int CAPTURE_EDGE = 0,
  parameter int CNT_W        = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          data_async,
  input  logic [STROBE_W-1:0]        strobe_async,
  input  logic                       cnt_clear,
  output logic [DATA_W-1:0]          data_sync,
  output logic [STROBE_W-1:0]        strobe_level,
  output logic [STROBE_W-1:0]        strobe_rise,
  output logic [STROBE_W-1:0]        strobe_fall,
  output logic [STROBE_W-1:0]        cap_valid,
  output logic [STROBE_W*DATA_W-1:0] data_cap,
  output logic [STROBE_W*CNT_W-1:0]  cap_count
);

  localparam int                FCNT_W    = $clog2(FILTER_LEN + 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [SYNC_STAGES-1:0][DATA_W-1:0]   data_p;
  logic [SYNC_STAGES-1:0][STROBE_W-1:0] strobe_p;
  logic [STROBE_W-1:0]                  strobe_sync;
  logic [STROBE_W-1:0][FCNT_W-1:0]      fcnt;
  logic [STROBE_W-1:0][FCNT_W-1:0]      fcnt_nxt;
  logic [STROBE_W-1:0]                  accept;
  logic [STROBE_W-1:0]                  rise_nxt;
  logic [STROBE_W-1:0]                  fall_nxt;
  logic [STROBE_W-1:0]                  cap_nxt;
  logic [STROBE_W-1:0][CNT_W-1:0]       cnt_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic edge_match(input logic rise, input logic fall);
    case (CAPTURE_EDGE)
      0:       return rise;
      1:       return fall;
      default: return rise | fall;
    endcase
  endfunction

  assign data_sync   = data_p[SYNC_STAGES-1];
  assign strobe_sync = strobe_p[SYNC_STAGES-1];

  always_comb begin
    accept   = '0;
    rise_nxt = '0;
    fall_nxt = '0;
    cap_nxt  = '0;
    fcnt_nxt = '0;
    cnt_nxt  = '0;
    for (int i = 0; i < STROBE_W; i++) begin
      // fcnt counts how long the synced level has disagreed with the accepted level
      if (strobe_sync[i] != strobe_level[i]) begin
        if (fcnt[i] == FCNT_LAST) accept[i] = 1'b1;
        else                      fcnt_nxt[i] = fcnt[i] + FCNT_W'(1);
      end
      rise_nxt[i] = accept[i] & strobe_sync[i];
      fall_nxt[i] = accept[i] & ~strobe_sync[i];
      cap_nxt[i]  = edge_match(rise_nxt[i], fall_nxt[i]);
      // clear first, then count a capture landing in the same cycle
      cnt_nxt[i] = cnt_clear ? '0 : cap_count[i*CNT_W +: CNT_W];
      if (cap_nxt[i]) cnt_nxt[i] = sat_inc(cnt_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p       <= '0;
      strobe_p     <= '0;
      fcnt         <= '0;
      strobe_level <= '0;
      strobe_rise  <= '0;
      strobe_fall  <= '0;
      cap_valid    <= '0;
      data_cap     <= '0;
      cap_count    <= '0;
    end else begin
      data_p       <= {data_p[SYNC_STAGES-2:0], data_async};
      strobe_p     <= {strobe_p[SYNC_STAGES-2:0], strobe_async};
      fcnt         <= fcnt_nxt;
      strobe_level <= strobe_level ^ accept;
      strobe_rise  <= rise_nxt;
      strobe_fall  <= fall_nxt;
      cap_valid    <= cap_nxt;
      cap_count    <= cnt_nxt;
      for (int i = 0; i < STROBE_W; i++) begin
        if (cap_nxt[i]) data_cap[i*DATA_W +: DATA_W] <= data_sync;
      end
    end
  end

endmodule

// File: doc/strobe_capture.md
# strobe_capture

Parametrised input front end for the sampling/replay designs. It synchronises an asynchronous data bus and a set of asynchronous strobe lines into the `clk` domain. Each strobe gets a glitch filter and edge detector, and the synced data word is latched into a per-channel capture register on the selected strobe edge. It sits between the board pins and the core logic, and replaces hand-written two-flop synchronisers at the top level.

## Interface
- `DATA_W`, 4: width of `data_async`.
- `STROBE_W`, 2: number of strobe channels.
- `SYNC_STAGES`, 2: synchroniser depth, applied to both data and strobes; legal range 2..4.
- `FILTER_LEN`, 3: consecutive synced samples needed to accept a strobe level change; legal range 1..15.
- `CAPTURE_EDGE`, 0: capture mode. 0 = rising, 1 = falling, 2 = both edges.
- `CNT_W`, 8: width of each per-channel capture counter.

Ports (clock and reset first):
- `clk`  in  1  sole clock; everything is sampled on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_async`  in  DATA_W  asynchronous data bus.
- `strobe_async`  in  STROBE_W  asynchronous strobes.
- `cnt_clear`  in  1  synchronous pulse; clears all capture counters.
- `data_sync`  out  DATA_W  synchronised data; last stage of the data chain.
- `strobe_level`  out  STROBE_W  filtered strobe levels.
- `strobe_rise`  out  STROBE_W  one-cycle pulse on each accepted 0→1 change.
- `strobe_fall`  out  STROBE_W  one-cycle pulse on each accepted 1→0 change.
- `cap_valid`  out  STROBE_W  one-cycle pulse when the channel's capture register updates.
- `data_cap`  out  STROBE_W*DATA_W  capture registers; channel i is at `[i*DATA_W +: DATA_W]`.
- `cap_count`  out  STROBE_W*CNT_W  capture counters; channel i is at `[i*CNT_W +: CNT_W]`.

## Operation
- **Reset.** Every flop clears to 0 immediately on `rst_n` low. This covers synchroniser stages, filter counters, `strobe_level`, pulses, `data_cap` and `cap_count`.
  - Assertion mid-filter or mid-pulse discards that work; no pulse is emitted.
  - After release, a strobe input that is already high is treated as a new rising change.
- **Synchroniser.** Each bit passes through a chain of `SYNC_STAGES` flops. `strobe_sync` is the last strobe stage and is internal.
- **Filter, per channel.** Each channel has a counter `fcnt` of width clog2(FILTER_LEN+1). Each cycle:
  - If `strobe_sync` equals `strobe_level`: `fcnt` <= 0.
  - Else if `fcnt` == FILTER_LEN-1: `strobe_level` <= `strobe_sync` and `fcnt` <= 0. This is the accept event.
  - Else: `fcnt` <= `fcnt` + 1.
  - A differing run shorter than FILTER_LEN is discarded.
  - FILTER_LEN=1 accepts on the first differing sample.
- **Edge pulses.** `strobe_rise` / `strobe_fall` are registered at the same edge as the accept event. They are high for exactly the first cycle in which the new `strobe_level` is visible. Rise and fall are never both high on one channel.
- **Capture.** On an accept event matching `CAPTURE_EDGE`:
  - `data_cap[i]` is loaded with the `data_sync` value present in the accepting cycle.
  - `cap_valid[i]` pulses alongside the edge pulse.
  - `cap_count[i]` increments.
  - Channels are independent. Simultaneous captures on several channels all load the same `data_sync` value.
- **Counters.**
  - Increment saturates at 2^CNT_W-1.
  - `cnt_clear` alone sets all counters to 0.
  - `cnt_clear` in the same cycle as a capture on channel i sets that counter to 1: the clear applies first, then the capture is counted.
- `data_cap` holds its value until the next capture. Reset is the only other way it changes.

## Timing
- Data latency: a `data_async` change sampled at edge E appears on `data_sync` after edge E+SYNC_STAGES-1.
- Strobe latency: for a clean change sampled at edge E0, `strobe_level`, the edge pulse and `cap_valid` update at edge E0+SYNC_STAGES+FILTER_LEN-1. With defaults that is 5 edges after and including E0.
- Minimum accepted strobe pulse width is FILTER_LEN clk cycles. Minimum spacing between accepted edges is also FILTER_LEN cycles.
- All outputs are registered. There is no combinational path from any input to any output.
- Data must be stable for at least FILTER_LEN+1 cycles around the strobe edge for a coherent capture. Multi-bit skew on `data_async` is not corrected.

## Test plan
- **Reset.** Hold `rst_n` low and drive all inputs to 1 → every output is 0. Release reset → `strobe_rise`=2'b11 and `cap_valid`=2'b11 at the 5th edge after release, and `data_cap` = {4'hF,4'hF}.
- **Clean rising strobe.** Defaults; `data_async`=4'hA, with `strobe_async[0]` rising before edge E0 → `strobe_rise[0]`, `cap_valid[0]` and `strobe_level[0]` appear after E4. `data_cap[3:0]`=4'hA and `cap_count[7:0]`=1. Channel 1 is unchanged.
- **Glitch rejection.** `strobe_async[1]` high for 2 cycles → no pulse, `strobe_level[1]` stays 0. The same line held high for exactly 3 cycles → it is accepted, then `strobe_fall[1]` follows 3 cycles later.
- **Both-edges mode.** `CAPTURE_EDGE`=2, `FILTER_LEN`=1; toggle `strobe_async[0]` 4 times with data 1,2,3,4 → 4 `cap_valid` pulses, final `data_cap[3:0]`=4, `cap_count`=4.
- **Counter saturation and clear.** `CNT_W`=2 with 5 captures → `cap_count` holds at 3. `cnt_clear` coinciding with a 6th capture → `cap_count`=1.
- **Asynchronous reset mid-filter.** Pulse `rst_n` low between E2 and E3 of a pending strobe rise → no rise pulse, and all outputs are 0 within the same cycle.
